// File: rtl/fpga_clk_div_gen_if.sv
// APB slave bus bundle for the clock-enable generator register file.
// No wait states: writes commit on the access edge, reads are combinational.
// No pready; the slave never stalls the master.
interface fpga_clk_div_gen_if #(
  parameter int ADDR_W = 8
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata
  );
endinterface

// File: rtl/fpga_clk_div_gen.sv
// Multi-channel APB-programmable clock-enable generator: tick every (ratio+1) cycles.
// Latency: ch_tick is combinational from flops and gate_en; first tick ratio+1 cycles after enable.
// Backpressure: none; APB has no wait states, ratio changes wait for the period boundary.
module fpga_clk_div_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                pad_clk,
  input  logic                clkrst_b,
  fpga_clk_div_gen_if.slave   apb,
  input  logic [NUM_CH-1:0]   gate_en,
  output logic [NUM_CH-1:0]   ch_tick
);

  localparam int IDX_W = ADDR_W - 2;

  // Reset synchroniser: asserts asynchronously, releases two edges after clkrst_b rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  // Shift ones into the synchroniser once the pad reset is released.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Synchroniser register, cleared the moment the pad reset goes low.
  always_ff @(posedge pad_clk or negedge clkrst_b) begin
    if (!clkrst_b) rst_sync_q <= '0;
    else           rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // Per-channel state: enable, shadow ratio, active ratio, pending flag, counter.
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [DIV_W-1:0]  ratio_q [NUM_CH];
  logic [DIV_W-1:0]  ratio_d [NUM_CH];
  logic [DIV_W-1:0]  act_q   [NUM_CH];
  logic [DIV_W-1:0]  act_d   [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] wrap;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;
  logic [31:0]       prdata_c;

  assign idx   = apb.paddr[ADDR_W-1:2];
  assign wr_en = apb.psel & apb.penable & apb.pwrite;

  // Low address bits and unmapped write-data bits are architecturally ignored.
  wire unused_ok = &{1'b0, apb.paddr[1:0], apb.pwdata};

  // A channel wraps when running and its counter reaches the active ratio.
  always_comb begin
    run  = '0;
    wrap = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      run[i]  = en_q[i] & gate_en[i];
      wrap[i] = run[i] & (cnt_q[i] == act_q[i]);
    end
  end

  assign ch_tick = wrap;

  // Next-state: register writes, deferred ratio hand-over at wrap, counter stepping.
  always_comb begin
    en_d    = en_q;
    pend_d  = pend_q;
    ratio_d = ratio_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && (int'(idx) == i)) begin
        en_d[i]    = apb.pwdata[31];
        ratio_d[i] = apb.pwdata[DIV_W-1:0];
        // An idle channel, a channel being disabled, or a write landing on the
        // boundary takes the new ratio at once; otherwise it waits for the wrap.
        if (!en_q[i] || !apb.pwdata[31] || wrap[i]) begin
          act_d[i]  = apb.pwdata[DIV_W-1:0];
          pend_d[i] = 1'b0;
        end else begin
          pend_d[i] = 1'b1;
        end
      end else if (pend_q[i] && wrap[i]) begin
        act_d[i]  = ratio_q[i];
        pend_d[i] = 1'b0;
      end

      // Gate low freezes the count; disable clears it.
      if (!en_q[i] || !en_d[i]) cnt_d[i] = '0;
      else if (!run[i])         cnt_d[i] = cnt_q[i];
      else if (wrap[i])         cnt_d[i] = '0;
      else                      cnt_d[i] = cnt_q[i] + DIV_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge pad_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      pend_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ratio_q[i] <= '0;
        act_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      en_q    <= en_d;
      pend_q  <= pend_d;
      ratio_q <= ratio_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read mux: CTRL returns en and the shadow ratio, STAT returns pending/running.
  always_comb begin
    prdata_c = '0;
    if (apb.psel && !apb.pwrite) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(idx) == i) begin
          prdata_c[31]        = en_q[i];
          prdata_c[DIV_W-1:0] = ratio_q[i];
        end
      end
      if (int'(idx) == NUM_CH) begin
        prdata_c[NUM_CH-1:0]  = pend_q;
        prdata_c[16+:NUM_CH]  = run;
      end
    end
  end

  assign apb.prdata = prdata_c;

endmodule

// File: tb/tb_fpga_clk_div_gen.sv
// Self-checking bench for fpga_clk_div_gen: vector tables, directed corner sequences,
// and randomized traffic compared every cycle against a countdown-based reference model.
// Inputs change 1 time unit after posedge; outputs are sampled on the negedge.
module tb_fpga_clk_div_gen;

  logic       pad_clk = 1'b0;
  logic       clkrst_b;
  logic [3:0] gate_en;
  logic [3:0] ch_tick;

  fpga_clk_div_gen_if #(.ADDR_W(8)) bus ();

  fpga_clk_div_gen #(.NUM_CH(4), .DIV_W(8), .ADDR_W(8)) dut (
    .pad_clk  (pad_clk),
    .clkrst_b (clkrst_b),
    .apb      (bus),
    .gate_en  (gate_en),
    .ch_tick  (ch_tick)
  );

  always #5 pad_clk = ~pad_clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  tick_s;
  logic [31:0] rd_s;

  // Reference model: per channel, how many running cycles remain before the tick.
  logic m_en   [4];
  logic m_pend [4];
  int   m_sh   [4];
  int   m_act  [4];
  int   m_left [4];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 1'b0; m_pend[i] = 1'b0;
      m_sh[i] = 0; m_act[i] = 0; m_left[i] = 0;
    end
  endtask

  function automatic logic [3:0] m_ticks();
    logic [3:0] t;
    for (int i = 0; i < 4; i++) t[i] = m_en[i] && gate_en[i] && (m_left[i] == 0);
    return t;
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    logic [31:0] r;
    r = '0;
    if (idx < 4) begin
      r[31]  = m_en[idx];
      r[7:0] = 8'(m_sh[idx]);
    end else if (idx == 4) begin
      for (int i = 0; i < 4; i++) begin
        r[i]      = m_pend[i];
        r[16 + i] = m_en[i] && gate_en[i];
      end
    end
    return r;
  endfunction

  task automatic m_update(input logic commit, input int idx, input logic [31:0] wd);
    logic [3:0] t;
    logic run, ne;
    int nr;
    t = m_ticks();
    for (int i = 0; i < 4; i++) begin
      run = m_en[i] && gate_en[i];
      if (commit && idx == i) begin
        nr = int'(wd[7:0]);
        ne = wd[31];
        m_sh[i] = nr;
        if (!m_en[i] || !ne || t[i]) begin
          m_act[i] = nr; m_pend[i] = 1'b0; m_left[i] = nr;
        end else begin
          m_pend[i] = 1'b1;
          if (run) m_left[i]--;
        end
        m_en[i] = ne;
      end else if (run) begin
        if (t[i]) begin
          if (m_pend[i]) begin
            m_act[i] = m_sh[i]; m_pend[i] = 1'b0;
          end
          m_left[i] = m_act[i];
        end else begin
          m_left[i]--;
        end
      end
    end
  endtask

  // One bus cycle: drive, compare on the negedge, advance the model, cross the posedge.
  task automatic step(input logic s, input logic pe, input logic w, input int idx, input logic [31:0] wd);
    bus.psel    = s;
    bus.penable = pe;
    bus.pwrite  = w;
    bus.paddr   = 8'(idx * 4);
    bus.pwdata  = wd;
    @(negedge pad_clk);
    check("tick", {28'd0, ch_tick}, {28'd0, m_ticks()});
    if (s && !w) check("prdata", bus.prdata, m_read(idx));
    tick_s = ch_tick;
    rd_s   = bus.prdata;
    m_update(s && pe && w, idx, wd);
    @(posedge pad_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic apb_wr(input int idx, input logic [31:0] wd);
    step(1'b1, 1'b0, 1'b1, idx, wd);
    step(1'b1, 1'b1, 1'b1, idx, wd);
  endtask

  task automatic apb_rd(input int idx, output logic [31:0] d);
    step(1'b1, 1'b0, 1'b0, idx, 32'h0);
    step(1'b1, 1'b1, 1'b0, idx, 32'h0);
    d = rd_s;
  endtask

  typedef struct { int idx; logic [31:0] exp; } rd_vec_t;
  typedef struct { int idx; logic [31:0] wd; logic [31:0] exp; } wr_vec_t;

  rd_vec_t rv [7];
  wr_vec_t wv [6];

  initial begin
    logic [31:0] d;
    logic [31:0] wd;
    int r;
    int ch;

    rv[0] = '{0, 32'h0};  rv[1] = '{1, 32'h0};  rv[2] = '{2, 32'h0};
    rv[3] = '{3, 32'h0};  rv[4] = '{4, 32'h0};  rv[5] = '{5, 32'h0};
    rv[6] = '{63, 32'h0};

    wv[0] = '{3, 32'h7FFF_FF5A, 32'h0000_005A};
    wv[1] = '{3, 32'h0000_0000, 32'h0000_0000};
    wv[2] = '{5, 32'hFFFF_FFFF, 32'h0000_0000};
    wv[3] = '{4, 32'hFFFF_FFFF, 32'h0000_0000};
    wv[4] = '{1, 32'h0000_01FF, 32'h0000_00FF};
    wv[5] = '{1, 32'h0000_0000, 32'h0000_0000};

    m_reset();
    clkrst_b    = 1'b0;
    gate_en     = 4'hF;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    #3;
    check("reset_tick", {28'd0, ch_tick}, 32'h0);
    check("reset_prdata", bus.prdata, 32'h0);
    repeat (3) @(posedge pad_clk);
    #2 clkrst_b = 1'b1;
    @(posedge pad_clk);
    #1;
    idle(3);

    // Reset register contents.
    for (int i = 0; i < 7; i++) begin
      apb_rd(rv[i].idx, d);
      check("t1_read", d, rv[i].exp);
    end

    // Write/readback with reserved bits, RO and unmapped slots.
    for (int i = 0; i < 6; i++) begin
      apb_wr(wv[i].idx, wv[i].wd);
      apb_rd(wv[i].idx, d);
      check("wr_readback", d, wv[i].exp);
    end

    // Ratio 3: tick on every 4th cycle, first one 4 cycles after the write edge.
    apb_wr(0, 32'h8000_0003);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      check("t2_tick0", {31'd0, tick_s[0]}, {31'd0, (k % 4) == 3});
    end

    // Mid-period ratio change to 1: old period finishes, then period 2.
    apb_wr(0, 32'h8000_0001);
    apb_rd(4, d);
    check("t3_tick_at_wrap", {31'd0, tick_s[0]}, 32'd1);
    check("t3_pending", {31'd0, d[0]}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("t3_tick0", {31'd0, tick_s[0]}, {31'd0, (k % 2) == 1});
    end
    apb_rd(4, d);
    check("t3_pending_clr", {31'd0, d[0]}, 32'd0);
    apb_rd(0, d);
    check("t3_ctrl0", d, 32'h8000_0001);

    // Ratio 5 on ch1, gate low for 3 cycles at count 2.
    apb_wr(1, 32'h8000_0005);
    idle(2);
    gate_en = 4'b1101;
    apb_rd(4, d);
    check("t4_running_low", {31'd0, d[17]}, 32'd0);
    check("t4_tick_low", {31'd0, tick_s[1]}, 32'd0);
    idle(1);
    check("t4_tick_low2", {31'd0, tick_s[1]}, 32'd0);
    gate_en = 4'hF;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("t4_tick1", {31'd0, tick_s[1]}, {31'd0, k == 3});
    end
    apb_rd(4, d);
    check("t4_running_high", {31'd0, d[17]}, 32'd1);

    // Ratio 0: continuous enable, then disable drops it on the next cycle.
    apb_wr(2, 32'h8000_0000);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("t5_tick_hi", {31'd0, tick_s[2]}, 32'd1);
    end
    apb_wr(2, 32'h0000_0000);
    idle(1);
    check("t5_tick_off", {31'd0, tick_s[2]}, 32'd0);
    apb_rd(2, d);
    check("t5_ctrl2", d, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) gate_en = 4'($urandom);
      if (r < 5) begin
        idle(1);
      end else if (r < 8) begin
        ch = $urandom_range(0, 5);
        wd = $urandom;
        wd[31] = ($urandom_range(0, 3) != 0);
        wd[7:0] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
        apb_wr(ch, wd);
      end else begin
        apb_rd($urandom_range(0, 6), d);
      end
    end

    // Reset while a ratio change is pending.
    gate_en = 4'hF;
    apb_wr(3, 32'h0000_0000);
    apb_wr(3, 32'h8000_0007);
    apb_wr(3, 32'h8000_0002);
    apb_rd(4, d);
    check("t6_pending_set", {31'd0, d[3]}, 32'd1);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 8'(4 * 4);
    clkrst_b    = 1'b0;
    #1;
    check("t6_rst_tick", {28'd0, ch_tick}, 32'h0);
    check("t6_rst_stat", bus.prdata, 32'h0);
    m_reset();
    repeat (3) @(posedge pad_clk);
    #2 clkrst_b = 1'b1;
    @(posedge pad_clk);
    #1;
    idle(12);
    apb_rd(4, d);
    check("t6_stat_after", d, 32'h0);
    apb_rd(3, d);
    check("t6_ctrl3_after", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
